avg_feeder: RTL and testbench
=============================

// Module: avg_feeder
// PURPOSE
//  Producer side of the averager sample interface (addValue/inputData in, averageReady/outputData out).
//  Buffers upstream samples in a small FIFO and issues paced single-cycle addValue strobes with inputData.
//  Captures each result signalled by averageReady and holds it for a downstream valid/ack consumer.
//  Sits between the sample source and the averager instance.
// PARAMETERS
//  DATA_W  32  sample/result width
//  DEPTH   4   FIFO entries (power of 2, >=2)
//  GAP     10  idle cycles forced after each addValue strobe (>=1)
// PORTS
//  clk            in   1       system clock, rising edge
//  n_rst          in   1       asynchronous active-low reset
//  sample_valid   in   1       upstream sample offered
//  sample_data    in   DATA_W  upstream sample
//  sample_ready   out  1       FIFO can accept (= !full)
//  addValue       out  1       one-cycle strobe to the averager
//  inputData      out  DATA_W  sample for the averager; valid while addValue=1
//  averageReady   in   1       averager result available (level)
//  averageData    in   DATA_W  averager outputData
//  result_valid   out  1       captured result pending
//  result_data    out  DATA_W  captured result
//  result_ack     in   1       consumer takes result (meaningful only when result_valid=1)
//  result_overrun out  1       sticky: an unacked result was overwritten
//  issued_count   out  16      strobes issued, wraps at 65535 -> 0
// BEHAVIOUR
//  Reset (async, n_rst=0):
//  - FIFO emptied; FSM -> IDLE; gap counter 0.
//  - Outputs: addValue=0, inputData=0, result_valid=0, result_data=0, result_overrun=0, issued_count=0.
//  - sample_ready=1 once reset is released. Reset mid-operation discards all buffered samples and pending results.
//  FIFO:
//  - Push when sample_valid & sample_ready.
//  - sample_ready depends only on full. When full, no push occurs, even if a pop happens the same cycle.
//  - Pop only from a non-empty FIFO; there is no bypass path. A sample pushed into an empty FIFO is popped no earlier than the next cycle.
//  - Pointers wrap mod DEPTH. Occupancy is tracked with a DEPTH+1-state count.
//  FSM (all outputs registered):
//  - IDLE: if FIFO non-empty -> pop head, set inputData=head, addValue=1, issued_count+=1, -> ISSUE.
//  - ISSUE: lasts one cycle. addValue=0, inputData holds its value, gap counter=GAP -> WAIT.
//  - WAIT: decrement the gap counter each cycle; -> IDLE when it reaches 1.
//  Latency and spacing:
//  - A sample accepted at edge k into an empty FIFO in IDLE gives addValue=1 from edge k+1 to k+2.
//  - Consecutive strobes start exactly GAP+2 edges apart when data is waiting.
//  Result capture:
//  - Captures on the rising edge of averageReady (ready registered and edge-detected).
//  - Capture happens one edge after averageReady is first sampled high: result_data<=averageData, result_valid<=1.
//  - result_ack with result_valid=1 clears result_valid at the next edge.
//  - Capture and ack in the same cycle: the capture wins, result_valid stays 1, no overrun.
//  - Capture while result_valid=1 with no ack: result_data is overwritten and result_overrun<=1 (sticky until reset).
//  - averageReady held high does not re-capture.
//  Sample path and result path are independent; neither stalls the other.
// TESTING
//  - Reset: n_rst=0 mid-WAIT with 3 samples queued -> all outputs at reset values, sample_ready=1, no strobe follows release.
//  - Single sample 1 pushed at edge k (GAP=10) -> addValue=1, inputData=1 for exactly one cycle at k+1; issued_count=1.
//  - Push 54321 x6 back-to-back (DEPTH=4):
//    - sample_ready drops when the FIFO is full.
//    - Strobes fall 12 edges apart, all with 54321.
//    - issued_count=6; nothing lost or duplicated.
//  - averageReady pulse with averageData=0x1234 -> result_valid=1, result_data=0x1234. Ack -> result_valid=0 next edge.
//  - Two averageReady pulses (0x10, 0x20), no ack -> result_data=0x20, result_overrun=1. Ack in the capture cycle instead -> result_valid=1, overrun=0.
//  - Preload issued_count=65535, then issue one strobe -> issued_count=0.

Source files
------------

// File: rtl/avg_feeder_if.sv
// rtl/avg_feeder_if.sv - sample, averager and result signal bundle for avg_feeder
interface avg_feeder_if #(
  parameter int DATA_W = 32
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              sample_ready;
  logic              addValue;
  logic [DATA_W-1:0] inputData;
  logic              averageReady;
  logic [DATA_W-1:0] averageData;
  logic              result_valid;
  logic [DATA_W-1:0] result_data;
  logic              result_ack;
  logic              result_overrun;
  logic [15:0]       issued_count;

  modport master (
    input  sample_valid, sample_data, averageReady, averageData, result_ack,
    output sample_ready, addValue, inputData, result_valid, result_data,
           result_overrun, issued_count
  );

  modport slave (
    output sample_valid, sample_data, averageReady, averageData, result_ack,
    input  sample_ready, addValue, inputData, result_valid, result_data,
           result_overrun, issued_count
  );
endinterface

// File: rtl/avg_feeder.sv
// rtl/avg_feeder.sv - FIFO-buffered, paced addValue feeder with result capture
// Samples drain one at a time with GAP idle cycles between strobes; results are held for a valid/ack consumer.
module avg_feeder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int GAP    = 10
) (
  input  logic        clk,
  input  logic        n_rst,
  avg_feeder_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              full, push, pop;

  state_t            state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              add_q, add_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       issued_q, issued_d;

  logic              rdy_q, rdy_prev_q, capture;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              overrun_q, overrun_d;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign full = (count_q == (AW+1)'(DEPTH));
  assign push = bus.sample_valid & ~full;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= bus.sample_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Pop looks only at the registered count, so a fresh sample is never bypassed.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    add_d    = 1'b0;
    data_d   = data_q;
    issued_d = issued_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          data_d   = mem[rd_ptr_q];
          add_d    = 1'b1;
          issued_d = issued_q + 16'd1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        gap_d   = GW'(GAP);
        state_d = WAIT;
      end
      WAIT: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == GW'(1))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      add_q    <= 1'b0;
      data_q   <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      add_q    <= add_d;
      data_q   <= data_d;
      issued_q <= issued_d;
    end
  end

  // A capture in the same cycle as an ack wins and is not an overrun.
  assign capture = rdy_q & ~rdy_prev_q;

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    overrun_d   = overrun_q;
    if (capture) begin
      res_valid_d = 1'b1;
      res_data_d  = bus.averageData;
      if (res_valid_q && !bus.result_ack)
        overrun_d = 1'b1;
    end else if (res_valid_q && bus.result_ack) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rdy_q       <= 1'b0;
      rdy_prev_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      rdy_q       <= bus.averageReady;
      rdy_prev_q  <= rdy_q;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.sample_ready   = ~full;
  assign bus.addValue       = add_q;
  assign bus.inputData      = data_q;
  assign bus.result_valid   = res_valid_q;
  assign bus.result_data    = res_data_q;
  assign bus.result_overrun = overrun_q;
  assign bus.issued_count   = issued_q;
endmodule

// File: tb/tb_avg_feeder.sv
// tb/tb_avg_feeder.sv - directed self-checking bench for avg_feeder
module tb_avg_feeder;
  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_errors;

  avg_feeder_if #(.DATA_W(32)) bus ();

  avg_feeder #(.DATA_W(32), .DEPTH(4), .GAP(10)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.averageReady = 1'b0;
    bus.averageData  = '0;
    bus.result_ack   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic pulse_ready(input logic [31:0] d);
    bus.averageData  = d;
    bus.averageReady = 1'b1;
    tick();
    bus.averageReady = 1'b0;
    tick();
  endtask

  initial begin
    int strobe_cyc[$];
    logic [31:0] strobe_dat[$];
    int pushed;
    int seen;
    logic saw_full;
    logic accepted;

    n_checks = 0;
    n_errors = 0;
    n_rst    = 1'b0;
    clear_inputs();
    tick();
    tick();
    n_rst = 1'b1;
    tick();

    check("rst_add",     bus.addValue, 0);
    check("rst_data",    bus.inputData, 0);
    check("rst_rvalid",  bus.result_valid, 0);
    check("rst_rdata",   bus.result_data, 0);
    check("rst_overrun", bus.result_overrun, 0);
    check("rst_issued",  bus.issued_count, 0);
    check("rst_ready",   bus.sample_ready, 1);

    // single sample: pushed at edge k, strobe high k+1..k+2
    bus.sample_valid = 1'b1;
    bus.sample_data  = 32'd1;
    tick();
    bus.sample_valid = 1'b0;
    check("single_k_add",   bus.addValue, 0);
    tick();
    check("single_add",     bus.addValue, 1);
    check("single_data",    bus.inputData, 1);
    check("single_issued",  bus.issued_count, 1);
    tick();
    check("single_add_low", bus.addValue, 0);
    check("single_hold",    bus.inputData, 1);

    // six back-to-back samples through a 4-deep FIFO
    do_reset();
    pushed   = 0;
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      bus.sample_valid = (pushed < 6);
      bus.sample_data  = 32'd54321;
      if (!bus.sample_ready) saw_full = 1'b1;
      accepted = bus.sample_valid && bus.sample_ready;
      tick();
      if (accepted) pushed++;
      if (bus.addValue) begin
        strobe_cyc.push_back(cyc);
        strobe_dat.push_back(bus.inputData);
      end
    end
    bus.sample_valid = 1'b0;
    check("b2b_full_seen", saw_full, 1);
    check("b2b_pushed",    pushed, 6);
    check("b2b_strobes",   strobe_cyc.size(), 6);
    check("b2b_issued",    bus.issued_count, 6);
    for (int i = 0; i < strobe_dat.size(); i++)
      check($sformatf("b2b_data%0d", i), strobe_dat[i], 32'd54321);
    for (int i = 1; i < strobe_cyc.size(); i++)
      check($sformatf("b2b_gap%0d", i), strobe_cyc[i] - strobe_cyc[i-1], 12);

    // reset mid-WAIT with 3 samples queued and a result pending
    do_reset();
    pulse_ready(32'h55);
    check("mid_rvalid_pre", bus.result_valid, 1);
    bus.sample_valid = 1'b1;
    bus.sample_data  = 32'd7;
    for (int i = 0; i < 4; i++) tick();
    bus.sample_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("mid_issued_pre", bus.issued_count, 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_rst_add",     bus.addValue, 0);
    check("mid_rst_data",    bus.inputData, 0);
    check("mid_rst_rvalid",  bus.result_valid, 0);
    check("mid_rst_rdata",   bus.result_data, 0);
    check("mid_rst_issued",  bus.issued_count, 0);
    tick();
    n_rst = 1'b1;
    check("mid_ready", bus.sample_ready, 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.addValue) seen++;
    end
    check("mid_no_strobe",    seen, 0);
    check("mid_issued_after", bus.issued_count, 0);

    // result capture and ack
    do_reset();
    bus.averageData  = 32'h1234;
    bus.averageReady = 1'b1;
    tick();
    check("cap_latency", bus.result_valid, 0);
    tick();
    bus.averageReady = 1'b0;
    check("cap_valid", bus.result_valid, 1);
    check("cap_data",  bus.result_data, 32'h1234);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    check("ack_clear",   bus.result_valid, 0);
    check("ack_overrun", bus.result_overrun, 0);

    // two results without ack
    pulse_ready(32'h10);
    pulse_ready(32'h20);
    check("ovr_data",    bus.result_data, 32'h20);
    check("ovr_valid",   bus.result_valid, 1);
    check("ovr_overrun", bus.result_overrun, 1);

    // ack in the capture cycle
    do_reset();
    pulse_ready(32'h10);
    bus.averageData  = 32'h20;
    bus.averageReady = 1'b1;
    tick();
    bus.averageReady = 1'b0;
    bus.result_ack   = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    check("capack_valid",   bus.result_valid, 1);
    check("capack_data",    bus.result_data, 32'h20);
    check("capack_overrun", bus.result_overrun, 0);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;

    // held-high averageReady captures once only
    bus.averageData  = 32'h33;
    bus.averageReady = 1'b1;
    tick();
    tick();
    check("hold_cap", bus.result_data, 32'h33);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("hold_no_recap", bus.result_valid, 0);
    bus.averageReady = 1'b0;

    // issued_count wrap
    do_reset();
    force dut.issued_q = 16'hffff;
    #1;
    release dut.issued_q;
    check("wrap_preload", bus.issued_count, 16'hffff);
    bus.sample_valid = 1'b1;
    bus.sample_data  = 32'd9;
    tick();
    bus.sample_valid = 1'b0;
    tick();
    check("wrap_add",    bus.addValue, 1);
    check("wrap_issued", bus.issued_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
